// File: rtl/vga_draw_scheduler.sv
// -----------------------------------------------------------------------------
// vga_draw_scheduler
//
// Time-shares one VGA adapter write port between NUM_DRAWERS drawer blocks.
// After reset the screen is swept with CLEAR_COLOR. Each drawer then runs to
// completion in index order while the others are held in reset. The
// scheduler then idles REFRESH_CYCLES cycles and redraws, so live values are
// refreshed periodically.
//
// Optional build macro: DRAW_TIMEOUT_EN
//   When defined, a drawer that has not signalled done by cycle
//   TIMEOUT_CYCLES-1 is forced to complete and the sticky timeout_err is set.
//   When undefined there is no watchdog and timeout_err stays 0.
//
// Ports
//   clock, resetn        system clock, asynchronous active-low reset
//   drawer_x/y/color     flattened per-drawer pixel buses (10/9/9 bits each)
//   drawer_done          per-drawer done level
//   drawer_resetn        per-drawer active-low reset, high only for the
//                        active drawer while drawing
//   refresh_req          skip the remaining idle wait and redraw now
//   clear_req            request a full clear before the next frame
//   vga_x/y/color/plot   registered pixel write to the VGA adapter
//   current_drawer       index of the active drawer
//   busy                 high while clearing or drawing
//   frame_done           one-cycle pulse when the last drawer completes
//   timeout_err          sticky watchdog flag
// -----------------------------------------------------------------------------
module vga_draw_scheduler #(
   parameter int         NUM_DRAWERS    = 3,
   parameter int         SEL_W          = 2,
   parameter int         SCREEN_W       = 640,
   parameter int         SCREEN_H       = 480,
   parameter logic [8:0] CLEAR_COLOR    = 9'b000000000,
   parameter int         REFRESH_CYCLES = 1000000,
   parameter int         TIMEOUT_CYCLES = 65536
) (
   input  logic                     clock,
   input  logic                     resetn,
   input  logic [NUM_DRAWERS*10-1:0] drawer_x,
   input  logic [NUM_DRAWERS*9-1:0]  drawer_y,
   input  logic [NUM_DRAWERS*9-1:0]  drawer_color,
   input  logic [NUM_DRAWERS-1:0]    drawer_done,
   output logic [NUM_DRAWERS-1:0]    drawer_resetn,
   input  logic                     refresh_req,
   input  logic                     clear_req,
   output logic [9:0]               vga_x,
   output logic [8:0]               vga_y,
   output logic [8:0]               vga_color,
   output logic                     vga_plot,
   output logic [SEL_W-1:0]         current_drawer,
   output logic                     busy,
   output logic                     frame_done,
   output logic                     timeout_err
);

   typedef enum logic [1:0] {S_CLEAR, S_DRAW, S_WAIT} state_e;

   localparam int              WCNT_W    = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
   localparam logic [9:0]      CX_LAST   = 10'(SCREEN_W - 1);
   localparam logic [8:0]      CY_LAST   = 9'(SCREEN_H - 1);
   localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(REFRESH_CYCLES - 1);
   localparam logic [19:0]     TO_LAST   = 20'(TIMEOUT_CYCLES - 1);
   localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(NUM_DRAWERS - 1);

`ifdef DRAW_TIMEOUT_EN
   localparam logic TO_EN = 1'b1;
`else
   localparam logic TO_EN = 1'b0;
`endif

   // state and counters
   state_e            state_q, state_d;
   logic [SEL_W-1:0]  sel_q, sel_d;
   logic [9:0]        cx_q, cx_d;
   logic [8:0]        cy_q, cy_d;
   logic [19:0]       cyc_q, cyc_d;
   logic [WCNT_W-1:0] wcnt_q, wcnt_d;
   logic              clear_pending_q, clear_pending_d;
   logic              timeout_err_q, timeout_err_d;

   // registered outputs
   logic [9:0]        vga_x_q, vga_x_d;
   logic [8:0]        vga_y_q, vga_y_d;
   logic [8:0]        vga_color_q, vga_color_d;
   logic              vga_plot_q, vga_plot_d;
   logic              frame_done_q, frame_done_d;
   logic              busy_q, busy_d;

   // active drawer's slice
   logic [9:0]        act_x;
   logic [8:0]        act_y;
   logic [8:0]        act_color;
   logic              act_done;
   logic              qual_done;
   logic              to_hit;
   logic              advance;

   always_comb begin
      act_x     = '0;
      act_y     = '0;
      act_color = '0;
      act_done  = 1'b0;
      for (int i = 0; i < NUM_DRAWERS; i++) begin
         if (sel_q == SEL_W'(i)) begin
            act_x     = drawer_x[i*10 +: 10];
            act_y     = drawer_y[i*9 +: 9];
            act_color = drawer_color[i*9 +: 9];
            act_done  = drawer_done[i];
         end
      end
   end

   // A drawer has only just left reset when cyc==0, so its done level is
   // stale that cycle and must not count.
   assign qual_done = act_done && (cyc_q != '0);
   assign to_hit    = TO_EN && (state_q == S_DRAW) && (cyc_q == TO_LAST) && !qual_done;
   assign advance   = (state_q == S_DRAW) && (qual_done || to_hit);

   // ---------------------------------------------------------------- state reg
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state_q         <= S_CLEAR;
         sel_q           <= '0;
         cx_q            <= '0;
         cy_q            <= '0;
         cyc_q           <= '0;
         wcnt_q          <= '0;
         clear_pending_q <= 1'b0;
         timeout_err_q   <= 1'b0;
         vga_x_q         <= '0;
         vga_y_q         <= '0;
         vga_color_q     <= '0;
         vga_plot_q      <= 1'b0;
         frame_done_q    <= 1'b0;
         busy_q          <= 1'b1;
      end else begin
         state_q         <= state_d;
         sel_q           <= sel_d;
         cx_q            <= cx_d;
         cy_q            <= cy_d;
         cyc_q           <= cyc_d;
         wcnt_q          <= wcnt_d;
         clear_pending_q <= clear_pending_d;
         timeout_err_q   <= timeout_err_d;
         vga_x_q         <= vga_x_d;
         vga_y_q         <= vga_y_d;
         vga_color_q     <= vga_color_d;
         vga_plot_q      <= vga_plot_d;
         frame_done_q    <= frame_done_d;
         busy_q          <= busy_d;
      end
   end

   // --------------------------------------------------------------- next state
   always_comb begin
      state_d         = state_q;
      sel_d           = sel_q;
      cx_d            = cx_q;
      cy_d            = cy_q;
      cyc_d           = cyc_q;
      wcnt_d          = wcnt_q;
      clear_pending_d = clear_pending_q | clear_req;
      timeout_err_d   = timeout_err_q | to_hit;

      case (state_q)
         S_CLEAR: begin
            if (cx_q == CX_LAST) begin
               cx_d = '0;
               if (cy_q == CY_LAST) begin
                  cy_d            = '0;
                  state_d         = S_DRAW;
                  sel_d           = '0;
                  cyc_d           = '0;
                  // a clear requested during the sweep is satisfied by it
                  clear_pending_d = 1'b0;
               end else begin
                  cy_d = cy_q + 9'd1;
               end
            end else begin
               cx_d = cx_q + 10'd1;
            end
         end

         S_DRAW: begin
            if (cyc_q != 20'hFFFFF) cyc_d = cyc_q + 20'd1;
            if (advance) begin
               if (sel_q == SEL_LAST) begin
                  state_d = S_WAIT;
                  wcnt_d  = '0;
               end else begin
                  sel_d = sel_q + SEL_W'(1);
                  cyc_d = '0;
               end
            end
         end

         S_WAIT: begin
            if (clear_pending_q) begin
               state_d         = S_CLEAR;
               cx_d            = '0;
               cy_d            = '0;
               clear_pending_d = 1'b0;
            end else if (refresh_req || (wcnt_q == WCNT_LAST)) begin
               state_d = S_DRAW;
               sel_d   = '0;
               cyc_d   = '0;
            end else begin
               wcnt_d = wcnt_q + WCNT_W'(1);
            end
         end

         default: state_d = S_CLEAR;
      endcase
   end

   // ------------------------------------------------------------------ outputs
   always_comb begin
      vga_x_d      = vga_x_q;
      vga_y_d      = vga_y_q;
      vga_color_d  = vga_color_q;
      vga_plot_d   = 1'b0;
      frame_done_d = 1'b0;
      busy_d       = (state_d != S_WAIT);

      case (state_q)
         S_CLEAR: begin
            vga_x_d     = cx_q;
            vga_y_d     = cy_q;
            vga_color_d = CLEAR_COLOR;
            vga_plot_d  = 1'b1;
         end
         S_DRAW: begin
            vga_x_d      = act_x;
            vga_y_d      = act_y;
            vga_color_d  = act_color;
            vga_plot_d   = !qual_done;
            frame_done_d = advance && (sel_q == SEL_LAST);
         end
         default: ;
      endcase
   end

   // drawer reset is combinational so a finished drawer is re-held the same
   // cycle its successor is released
   always_comb begin
      drawer_resetn = '0;
      for (int i = 0; i < NUM_DRAWERS; i++)
         drawer_resetn[i] = (state_q == S_DRAW) && (sel_q == SEL_W'(i));
   end

   assign vga_x          = vga_x_q;
   assign vga_y          = vga_y_q;
   assign vga_color      = vga_color_q;
   assign vga_plot       = vga_plot_q;
   assign current_drawer = sel_q;
   assign busy           = busy_q;
   assign frame_done     = frame_done_q;
   assign timeout_err    = timeout_err_q;

endmodule
